irrigation_actuator_sequencer: RTL

- Downstream consumer of the irrigation decision logic. Takes the level-style Gotejamento/Aspersao requests and Alarme, and sequences the physical actuators: pump spin-up, valve opening, minimum run time and post-run lockout.
- Prevents valve chatter from sensor noise and guarantees the pump never runs dry.
- Time base is a 1-clock Tick strobe supplied by a prescaler elsewhere.

---
 rtl/irrigation_actuator_sequencer_pkg.sv | 29 ++
 rtl/irrigation_actuator_sequencer_if.sv | 27 ++
 rtl/irrigation_actuator_sequencer_tick_timer.sv | 29 ++
 rtl/irrigation_actuator_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/irrigation_actuator_sequencer_pkg.sv
// Shared types and defaults for the irrigation actuator sequencer.
// State codes are exported on Estado, so their numeric values are fixed.
package irrigation_actuator_sequencer_pkg;

  localparam int ESTADO_W = 3;
  localparam int CICLOS_W = 8;
  localparam int RUN_W    = 16;

  localparam int DEF_PRIME_TICKS    = 3;
  localparam int DEF_MIN_ON_TICKS   = 10;
  localparam int DEF_COOLDOWN_TICKS = 5;
  localparam int DEF_TIMER_W        = 8;
  localparam int DEF_MAX_RUN_TICKS  = 600;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    DRIP     = 3'd2,
    SPRAY    = 3'd3,
    COOLDOWN = 3'd4,
    FAULT    = 3'd5
  } estado_t;

  typedef enum logic {
    MODE_DRIP  = 1'b0,
    MODE_SPRAY = 1'b1
  } mode_t;

endpackage

// File: rtl/irrigation_actuator_sequencer_if.sv
// Request/actuator bundle between the decision logic (master) and the sequencer (slave).
// Level-style requests plus a Tick strobe in; pump/valve enables and status out.
interface irrigation_actuator_sequencer_if;
  import irrigation_actuator_sequencer_pkg::*;

  logic                Tick;
  logic                Gotejamento;
  logic                Aspersao;
  logic                Alarme;
  logic                Bomba;
  logic                ValvulaGotejo;
  logic                ValvulaAspersor;
  logic [ESTADO_W-1:0] Estado;
  logic [CICLOS_W-1:0] CiclosConcluidos;
  logic                Falha;

  modport master (
    output Tick, Gotejamento, Aspersao, Alarme,
    input  Bomba, ValvulaGotejo, ValvulaAspersor, Estado, CiclosConcluidos, Falha
  );

  modport slave (
    input  Tick, Gotejamento, Aspersao, Alarme,
    output Bomba, ValvulaGotejo, ValvulaAspersor, Estado, CiclosConcluidos, Falha
  );

endinterface

// File: rtl/irrigation_actuator_sequencer_tick_timer.sv
// Saturating tick counter with a "N ticks elapsed" flag; clear has priority over counting.
// elapsed is combinational: true on the edge completing tick N and for as long as count >= N.
module irrigation_actuator_sequencer_tick_timer #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] n,
  output logic         elapsed
);

  logic [W-1:0] count;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // Covers both the completing-tick edge and any later edge once the count is reached.
  assign elapsed = (count >= n) || (en && (count == n - 1'b1));

endmodule

// File: rtl/irrigation_actuator_sequencer.sv
// Pump/valve sequencer: prime, run with minimum on-time, cooldown lockout; outputs decode registered state.
// No backpressure (level inputs, Tick strobe); MAX_RUN_TIMEOUT_EN adds the run-timeout FAULT state.
module irrigation_actuator_sequencer
  import irrigation_actuator_sequencer_pkg::*;
#(
  parameter int PRIME_TICKS    = DEF_PRIME_TICKS,
  parameter int MIN_ON_TICKS   = DEF_MIN_ON_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int TIMER_W        = DEF_TIMER_W
`ifdef MAX_RUN_TIMEOUT_EN
  ,
  parameter int MAX_RUN_TICKS  = DEF_MAX_RUN_TICKS
`endif
) (
  input logic                          Clock,
  input logic                          Reset_n,
  irrigation_actuator_sequencer_if.slave io
);

  estado_t             state;
  estado_t             nextState;
  mode_t               mode;
  logic [CICLOS_W-1:0] ciclos;
  logic [TIMER_W-1:0]  phaseN;
  logic                phaseClear;
  logic                phaseElapsed;
  logic                latchedReq;
  logic                anyReq;
  logic                runEnds;
`ifdef MAX_RUN_TIMEOUT_EN
  logic                runElapsed;
`endif

  assign anyReq     = io.Gotejamento | io.Aspersao;
  assign latchedReq = (mode == MODE_SPRAY) ? io.Aspersao : io.Gotejamento;
  assign phaseClear = (nextState != state);
  assign runEnds    = ((state == DRIP) || (state == SPRAY)) && (nextState == COOLDOWN);

  always_comb begin
    phaseN = TIMER_W'(COOLDOWN_TICKS);
    case (state)
      PRIME:       phaseN = TIMER_W'(PRIME_TICKS);
      DRIP, SPRAY: phaseN = TIMER_W'(MIN_ON_TICKS);
      default:     phaseN = TIMER_W'(COOLDOWN_TICKS);
    endcase
  end

  irrigation_actuator_sequencer_tick_timer #(
    .W(TIMER_W)
  ) u_phaseTimer (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .clear   (phaseClear),
    .en      (io.Tick),
    .n       (phaseN),
    .elapsed (phaseElapsed)
  );

`ifdef MAX_RUN_TIMEOUT_EN
  // Shares the phase clear, so it restarts on entry to DRIP/SPRAY; its value elsewhere is ignored.
  irrigation_actuator_sequencer_tick_timer #(
    .W(RUN_W)
  ) u_runTimer (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .clear   (phaseClear),
    .en      (io.Tick),
    .n       (RUN_W'(MAX_RUN_TICKS)),
    .elapsed (runElapsed)
  );
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (!io.Alarme && anyReq) begin
          nextState = PRIME;
        end
      end
      PRIME: begin
        if (io.Alarme || !latchedReq) begin
          nextState = IDLE;
        end else if (phaseElapsed) begin
          nextState = (mode == MODE_SPRAY) ? SPRAY : DRIP;
        end
      end
      DRIP, SPRAY: begin
        if (io.Alarme) begin
          nextState = COOLDOWN;
`ifdef MAX_RUN_TIMEOUT_EN
        end else if (runElapsed) begin
          nextState = FAULT;
`endif
        end else if (!latchedReq && phaseElapsed) begin
          nextState = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (phaseElapsed) begin
          nextState = IDLE;
        end
      end
      FAULT: begin
        if (!anyReq) begin
          nextState = COOLDOWN;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      mode   <= MODE_DRIP;
      ciclos <= '0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && (nextState == PRIME)) begin
        mode <= io.Aspersao ? MODE_SPRAY : MODE_DRIP;
      end
      if (runEnds) begin
        ciclos <= ciclos + 1'b1;
      end
    end
  end

  assign io.Bomba            = (state == PRIME) || (state == DRIP) || (state == SPRAY);
  assign io.ValvulaGotejo    = (state == DRIP);
  assign io.ValvulaAspersor  = (state == SPRAY);
  assign io.Estado           = state;
  assign io.CiclosConcluidos = ciclos;
`ifdef MAX_RUN_TIMEOUT_EN
  assign io.Falha            = (state == FAULT);
`else
  assign io.Falha            = 1'b0;
`endif

endmodule
